// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller for a 5-stage pipeline.
// Ports: clk_i/rst_i clock and async active-high reset; cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i
// MEM-stage access; cpu_rdata_o load data; cpu_stall_o pipeline freeze; mem_req_o/mem_we_o/
// mem_addr_o/mem_wdata_o line transfer request; mem_rdata_i/mem_ack_i fill data and completion.
// Optional: define DCACHE_PERF_CNT_EN for saturating hit_cnt_o/miss_cnt_o counters.
module dcache_ctrl #(
  parameter int NUM_LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [15:0]  hit_cnt_o,
  output logic [15:0]  miss_cnt_o
`endif
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 27 - IW;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILLED} state_t;
  state_t r_state, w_next;
  logic [255:0]         r_data [NUM_LINES];
  logic [TW-1:0]        r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid, r_dirty;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [7:0]    w_bit;
  logic w_hit, w_hit_ev, w_miss_ev, w_store, w_fill;
  assign w_idx     = cpu_addr_i[5 +: IW];
  assign w_tag     = cpu_addr_i[31 -: TW];
  assign w_bit     = {cpu_addr_i[4:2], 5'b0};
  assign w_hit     = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_hit_ev  = r_state == IDLE && cpu_req_i && w_hit;
  assign w_miss_ev = r_state == IDLE && cpu_req_i && !w_hit;
  assign w_store   = w_hit_ev && cpu_we_i;
  assign w_fill    = r_state == ALLOCATE && mem_ack_i;
  assign cpu_rdata_o = r_data[w_idx][w_bit +: 32];
  assign mem_wdata_o = r_data[w_idx];
  always_comb begin
    w_next      = r_state;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    case (r_state)
      IDLE: begin
        // valid bits are cleared while in reset, so suppress the would-be miss stall
        cpu_stall_o = w_miss_ev && !rst_i;
        if (w_miss_ev) w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {r_tag[w_idx], w_idx, 5'b0};
        if (mem_ack_i) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {w_tag, w_idx, 5'b0};
        if (mem_ack_i) w_next = FILLED;
      end
      default: begin
        cpu_stall_o = 1'b1;
        w_next      = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_store) r_dirty[w_idx] <= 1'b1;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end
  // tag and data arrays carry no reset; valid bits make their contents irrelevant
  always_ff @(posedge clk_i) begin
    if (w_store) r_data[w_idx][w_bit +: 32] <= cpu_wdata_i;
    if (w_fill) begin
      r_data[w_idx] <= mem_rdata_i;
      r_tag[w_idx]  <= w_tag;
    end
  end
`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_ev && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (w_miss_ev && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a latency-programmable backing memory.
module tb_dcache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = '0;
  logic         mem_ack_i = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
  logic [15:0]  hit_cnt_o, miss_cnt_o;
`endif
  dcache_ctrl #(.NUM_LINES(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_stall_o(cpu_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  typedef struct {logic [31:0] rd; bit chk; int stall;} cpu_exp_t;
  typedef struct {bit we; logic [31:0] addr; bit chk_w; logic [31:0] w1;} mem_exp_t;
  cpu_exp_t cq[$];
  mem_exp_t mq[$];
  int checks = 0;
  int failures = 0;
  int lat = 3;
  bit mem_en = 1'b1;
  bit force_ack = 1'b0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [255:0] fill(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'h1000_0000 + {a[31:5], 5'b0} + 32'(w * 4);
    return l;
  endfunction
  // cpu monitor: counts stall cycles of the current access, checks on completion
  int sc = 0;
  always @(negedge clk_i) begin
    if (rst_i) sc = 0;
    else if (cpu_req_i) begin
      if (cpu_stall_o) sc++;
      else if (cq.size() == 0) chk("cpu_unexpected", 32'd1, 32'd0);
      else begin
        cpu_exp_t e;
        e = cq.pop_front();
        chk("stall_cycles", sc, e.stall);
        if (e.chk) chk("rdata", cpu_rdata_o, e.rd);
        sc = 0;
      end
    end
  end
  // backing memory plus mem-side monitor
  int cnt = 0;
  bit first = 1'b1;
  logic [288:0] saved;
  always @(negedge clk_i) begin
    mem_ack_i = force_ack;
    if (rst_i) begin
      cnt = 0;
      first = 1'b1;
    end else if (mem_req_o) begin
      if (first) begin
        if (mq.size() == 0) chk("mem_unexpected", mem_addr_o, 32'hFFFF_FFFF);
        else begin
          mem_exp_t e;
          e = mq.pop_front();
          chk("mem_we", {31'd0, mem_we_o}, {31'd0, e.we});
          chk("mem_addr", mem_addr_o, e.addr);
          if (e.chk_w) chk("mem_wdata_w1", mem_wdata_o[63:32], e.w1);
        end
        saved = {mem_we_o, mem_addr_o, mem_wdata_o};
        first = 1'b0;
      end else if (saved !== {mem_we_o, mem_addr_o, mem_wdata_o}) chk("mem_stable", 32'd1, 32'd0);
      cnt++;
      if (mem_en && cnt == lat) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = fill(mem_addr_o);
        cnt = 0;
        first = 1'b1;
      end
    end else begin
      cnt = 0;
      first = 1'b1;
    end
  end
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input bit c, input int st);
    cq.push_back('{rd, c, st});
    cpu_we_i = we;
    cpu_addr_i = a;
    cpu_wdata_i = wd;
    cpu_req_i = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) break;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL access_timeout addr=%h", a);
        break;
      end
    end
    @(posedge clk_i);
    #1 cpu_req_i = 1'b0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    cpu_req_i = 1'b1;
    cpu_addr_i = 32'h40;
    #3;
    chk("rst_stall", {31'd0, cpu_stall_o}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    cpu_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    lat = 3;
    mq.push_back('{1'b0, 32'h40, 1'b0, 32'h0});
    access(1'b0, 32'h40, 32'h0, 32'h1000_0040, 1'b1, 5);
    access(1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    access(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 1'b1, 0);
    access(1'b0, 32'h48, 32'h0, 32'h1000_0048, 1'b1, 0);
    lat = 1;
    mq.push_back('{1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF});
    mq.push_back('{1'b0, 32'h440, 1'b0, 32'h0});
    access(1'b0, 32'h440, 32'h0, 32'h1000_0440, 1'b1, 4);
    lat = 2;
    mq.push_back('{1'b0, 32'h80, 1'b0, 32'h0});
    access(1'b1, 32'h8C, 32'h1234_5678, 32'h0, 1'b0, 4);
    access(1'b0, 32'h8C, 32'h0, 32'h1234_5678, 1'b1, 0);
    access(1'b0, 32'h80, 32'h0, 32'h1000_0080, 1'b1, 0);
    mem_en = 1'b0;
    mq.push_back('{1'b0, 32'h40, 1'b0, 32'h0});
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h40;
    cpu_req_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("alloc_req", {31'd0, mem_req_o}, 32'd1);
    chk("alloc_addr", mem_addr_o, 32'h40);
    #2 rst_i = 1'b1;
    #1;
    chk("abort_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("abort_stall", {31'd0, cpu_stall_o}, 32'd0);
    chk("abort_mem_we", {31'd0, mem_we_o}, 32'd0);
    cpu_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    force_ack = 1'b1;
    @(posedge clk_i);
    #1 force_ack = 1'b0;
    @(negedge clk_i);
    chk("late_ack_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("late_ack_stall", {31'd0, cpu_stall_o}, 32'd0);
    @(posedge clk_i);
    #1 mem_en = 1'b1;
    lat = 3;
    mq.push_back('{1'b0, 32'h40, 1'b0, 32'h0});
    access(1'b0, 32'h40, 32'h0, 32'h1000_0040, 1'b1, 5);
    mq.push_back('{1'b0, 32'h80, 1'b0, 32'h0});
    access(1'b0, 32'h8C, 32'h0, 32'h1000_008C, 1'b1, 5);
`ifdef DCACHE_PERF_CNT_EN
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("hit_cnt_rst", {16'd0, hit_cnt_o}, 32'd0);
    chk("miss_cnt_rst", {16'd0, miss_cnt_o}, 32'd0);
    lat = 1;
    mq.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    access(1'b0, 32'h100, 32'h0, 32'h1000_0100, 1'b1, 3);
    mq.push_back('{1'b0, 32'h120, 1'b0, 32'h0});
    access(1'b0, 32'h120, 32'h0, 32'h1000_0120, 1'b1, 3);
    mq.push_back('{1'b0, 32'h140, 1'b0, 32'h0});
    access(1'b0, 32'h140, 32'h0, 32'h1000_0140, 1'b1, 3);
    for (int i = 0; i < 70000; i++) cq.push_back('{32'h1000_0100, 1'b1, 0});
    cpu_addr_i = 32'h100;
    cpu_req_i = 1'b1;
    repeat (70000) @(posedge clk_i);
    #1 cpu_req_i = 1'b0;
    chk("miss_cnt", {16'd0, miss_cnt_o}, 32'd3);
    chk("hit_cnt_sat", {16'd0, hit_cnt_o}, 32'h0000_FFFF);
`endif
    repeat (3) @(posedge clk_i);
    chk("cpu_queue_empty", cq.size(), 32'd0);
    chk("mem_queue_empty", mq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
